// File: rtl/rmii_rx.sv
// RMII receive path: preamble/SFD detection, dibit-to-byte assembly,
// running CRC-32 residue check and frame-level error reporting.
module rmii_rx #(
  parameter int unsigned MIN_PREAMBLE = 8,
  parameter int unsigned MAX_BYTES    = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  input  logic        eth_rxer,
  output logic        byte_valid,
  output logic [7:0]  byte_out,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        frame_err,
  output logic [10:0] byte_count
);

  localparam int unsigned PW      = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PMIN  = PW'(MIN_PREAMBLE);
  localparam logic [10:0] BMAX    = 11'(MAX_BYTES);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_dcnt;
  logic [7:0]    r_shift;
  logic [31:0]   r_crc;
  logic          r_err;
  logic          r_from_data;
  logic          r_byte_valid;
  logic [7:0]    r_byte_out;
  logic          r_frame_done;
  logic          r_crc_ok;
  logic          r_frame_err;
  logic [10:0]   r_byte_count;

  logic [7:0]    w_byte;
  logic          w_end_err;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // New dibit enters at the top so the first dibit ends up in bits [1:0].
  assign w_byte    = {eth_rxd, r_shift[7:2]};
  assign w_end_err = r_err || (r_dcnt != 2'd0) || (r_byte_count < 11'd64);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_dcnt       <= '0;
      r_shift      <= '0;
      r_crc        <= '1;
      r_err        <= 1'b0;
      r_from_data  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_out   <= '0;
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (eth_crsdv) begin
            if (eth_rxd == 2'b01) begin
              r_state <= S_PREAMBLE;
              r_pcnt  <= PW'(1);
            end else if (eth_rxd != 2'b00) begin
              r_state     <= S_DROP;
              r_from_data <= 1'b0;
            end
          end
        end
        S_PREAMBLE: begin
          if (!eth_crsdv) begin
            r_state <= S_IDLE;
          end else if (eth_rxd == 2'b01) begin
            if (r_pcnt < PMIN) r_pcnt <= r_pcnt + PW'(1);
          end else if (eth_rxd == 2'b11 && r_pcnt >= PMIN) begin
            r_state      <= S_DATA;
            r_byte_count <= '0;
            r_crc        <= '1;
            r_dcnt       <= '0;
            r_err        <= 1'b0;
          end else begin
            r_state     <= S_DROP;
            r_from_data <= 1'b0;
          end
        end
        S_DATA: begin
          if (!eth_crsdv) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
            r_crc_ok     <= (r_crc == RESIDUE) && !w_end_err;
            r_frame_err  <= w_end_err;
          end else begin
            if (eth_rxer) r_err <= 1'b1;
            r_shift <= w_byte;
            r_dcnt  <= r_dcnt + 2'd1;
            if (r_dcnt == 2'd3) begin
              if (r_byte_count == BMAX) begin
                r_err       <= 1'b1;
                r_state     <= S_DROP;
                r_from_data <= 1'b1;
              end else begin
                r_byte_valid <= 1'b1;
                r_byte_out   <= w_byte;
                r_byte_count <= r_byte_count + 11'd1;
                r_crc        <= crc_byte(r_crc, w_byte);
              end
            end
          end
        end
        S_DROP: begin
          if (!eth_crsdv) begin
            r_state <= S_IDLE;
            if (r_from_data) begin
              r_frame_done <= 1'b1;
              r_frame_err  <= 1'b1;
            end
            r_from_data <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_out   = r_byte_out;
  assign frame_done = r_frame_done;
  assign crc_ok     = r_crc_ok;
  assign frame_err  = r_frame_err;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx: a table of frame scenarios driven dibit by
// dibit, with received bytes and frame status compared to hand values.
module tb_rmii_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        eth_crsdv;
  logic [1:0]  eth_rxd;
  logic        eth_rxer;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        frame_done;
  logic        crc_ok;
  logic        frame_err;
  logic [10:0] byte_count;

  always #10 clk = ~clk;

  rmii_rx #(.MIN_PREAMBLE(8), .MAX_BYTES(1522)) dut (
    .clk(clk), .rst(rst), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
    .eth_rxer(eth_rxer), .byte_valid(byte_valid), .byte_out(byte_out),
    .frame_done(frame_done), .crc_ok(crc_ok), .frame_err(frame_err),
    .byte_count(byte_count)
  );

  // Observer: records strobed bytes and frame_done status.
  int unsigned bv_total   = 0;
  int unsigned done_total = 0;
  int unsigned viol       = 0;
  logic [7:0]  rx_mem [0:4095];
  logic        last_ok, last_err;
  logic [10:0] last_cnt;

  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      rx_mem[bv_total % 4096] = byte_out;
      bv_total++;
    end
    if (frame_done === 1'b1) begin
      done_total++;
      last_ok  = crc_ok;
      last_err = frame_err;
      last_cnt = byte_count;
    end else if (crc_ok === 1'b1 || frame_err === 1'b1) begin
      viol++;
    end
  end

  typedef struct {
    int pre; int pay; bit fcs; int flip; int extra; int rxer_at; int rst_at;
    int exp_n; bit exp_done; bit exp_ok; bit exp_err; int exp_cnt;
  } vec_t;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  fr [0:1599];
  int unsigned fr_len;
  bit          rst_chk = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " byte_valid"}, byte_valid, 0);
    chk({nm, " byte_out"},   byte_out,   0);
    chk({nm, " frame_done"}, frame_done, 0);
    chk({nm, " crc_ok"},     crc_ok,     0);
    chk({nm, " frame_err"},  frame_err,  0);
    chk({nm, " byte_count"}, byte_count, 0);
  endtask

  // One dibit per call; a pending reset check runs one cycle after rst was driven.
  task automatic dib(input logic c, input logic [1:0] d, input logic e, input logic r);
    @(negedge clk);
    if (rst_chk) begin
      chk_zero("mid-frame reset");
      rst_chk = 0;
    end
    rst = r; eth_crsdv = c; eth_rxd = d; eth_rxer = e;
    if (r) rst_chk = 1;
  endtask

  function automatic logic [31:0] fcs_of(input int unsigned n);
    logic [31:0] c;
    c = '1;
    for (int unsigned i = 0; i < n; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int unsigned k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  initial begin
    vec_t        tbl [11];
    vec_t        v;
    logic [31:0] f;
    logic [7:0]  bv;
    int unsigned base_bv, base_done, base_viol, n, bad, lim, dcount;
    string       tag;

    //           pre pay  fcs flip ext rxer rst   n    done ok err cnt
    tbl[0]  = '{31,  60,  1,  -1,  0,  -1,  -1,  64,   1,  1,  0,  64};
    tbl[1]  = '{31,  60,  1,  10,  0,  -1,  -1,  64,   1,  0,  0,  64};
    tbl[2]  = '{ 4,  60,  1,  -1,  0,  -1,  -1,   0,   0,  0,  0,   0};
    tbl[3]  = '{ 8,  60,  1,  -1,  0,  -1,  -1,  64,   1,  1,  0,  64};
    tbl[4]  = '{ 7,  60,  1,  -1,  0,  -1,  -1,   0,   0,  0,  0,   0};
    tbl[5]  = '{31,  60,  1,  -1,  2,  -1,  -1,  64,   1,  0,  1,  64};
    tbl[6]  = '{31,  60,  1,  -1,  0, 100,  -1,  64,   1,  0,  1,  64};
    tbl[7]  = '{31,  40,  1,  -1,  0,  -1,  -1,  44,   1,  0,  1,  44};
    tbl[8]  = '{ 8,1600,  0,  -1,  0,  -1,  -1,1522,   1,  0,  1,1522};
    tbl[9]  = '{31,  60,  1,  -1,  0,  -1,  20,  20,   0,  0,  0,   0};
    tbl[10] = '{31,  60,  1,  -1,  0,  -1,  -1,  64,   1,  1,  0,  64};

    rst = 1'b1; eth_crsdv = 1'b0; eth_rxd = 2'b00; eth_rxer = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int unsigned t = 0; t < 11; t++) begin
      v = tbl[t];
      for (int unsigned i = 0; i < 1600; i++) fr[i] = i[7:0];
      fr_len = v.pay;
      if (v.fcs) begin
        f = fcs_of(v.pay);
        for (int unsigned j = 0; j < 4; j++) fr[v.pay + j] = f[8*j +: 8];
        fr_len = v.pay + 4;
      end
      if (v.flip >= 0) fr[v.flip] = fr[v.flip] ^ 8'h04;

      base_bv = bv_total; base_done = done_total; base_viol = viol;
      for (int p = 0; p < v.pre; p++) dib(1'b1, 2'b01, 1'b0, 1'b0);
      dib(1'b1, 2'b11, 1'b0, 1'b0);
      dcount = 0;
      for (int unsigned b = 0; b < fr_len; b++) begin
        bv = fr[b];
        for (int unsigned k = 0; k < 4; k++) begin
          dib(1'b1, bv[2*k +: 2], (int'(dcount) == v.rxer_at),
              (int'(b) == v.rst_at && k == 0));
          dcount++;
        end
      end
      for (int e = 0; e < v.extra; e++) dib(1'b1, 2'b10, 1'b0, 1'b0);
      repeat (8) dib(1'b0, 2'b00, 1'b0, 1'b0);
      @(negedge clk);

      tag = $sformatf("v%0d", t);
      n = bv_total - base_bv;
      chk({tag, " strobes"}, n, v.exp_n);
      bad = 0;
      lim = (n < v.exp_n) ? n : v.exp_n;
      for (int unsigned i = 0; i < lim; i++)
        if (rx_mem[(base_bv + i) % 4096] !== fr[i]) bad++;
      chk({tag, " byte mismatches"}, bad, 0);
      chk({tag, " frame_done pulses"}, done_total - base_done, v.exp_done);
      chk({tag, " crc_ok/frame_err outside frame_done"}, viol - base_viol, 0);
      if (v.exp_done) begin
        chk({tag, " crc_ok"},         last_ok,    v.exp_ok);
        chk({tag, " frame_err"},      last_err,   v.exp_err);
        chk({tag, " byte_count"},     last_cnt,   v.exp_cnt);
        chk({tag, " byte_count held"}, byte_count, v.exp_cnt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 Parameter MIN_PREAMBLE, default 8, minimum count of consecutive 2'b01 dibits that must precede the SFD dibit.
REQ-002 Parameter MAX_BYTES, default 1522, maximum accepted bytes per frame after the SFD, FCS included.
REQ-003 clk  input  1  RMII 50 MHz reference clock; one dibit sampled per rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 eth_crsdv  input  1  RMII carrier-sense/data-valid.
REQ-006 eth_rxd  input  2  RMII receive dibit, bit order LSB-pair first.
REQ-007 eth_rxer  input  1  PHY receive-error indication.
REQ-008 byte_valid  output  1  one-cycle strobe, byte_out is valid.
REQ-009 byte_out  output  8  assembled frame byte (destination MAC onward, FCS bytes included).
REQ-010 frame_done  output  1  one-cycle strobe at end of a frame that reached DATA.
REQ-011 crc_ok  output  1  valid with frame_done; FCS residue correct and no frame_err.
REQ-012 frame_err  output  1  valid with frame_done; alignment, length, overflow or rxer error.
REQ-013 byte_count  output  11  bytes received in current/last frame; valid with frame_done.

Function
REQ-014 The FSM SHALL have states IDLE, PREAMBLE, DATA, DROP, with all transitions evaluated on inputs sampled at the rising edge of clk.
REQ-015 IDLE: crsdv=1 and rxd=01 -> PREAMBLE with preamble count=1; crsdv=1 and rxd=00 -> stay IDLE; crsdv=1 and rxd=10/11 -> DROP.
REQ-016 PREAMBLE: rxd=01 -> count+1 (saturating); rxd=11 with count>=MIN_PREAMBLE -> DATA; rxd=11 with count<MIN_PREAMBLE, or rxd=00/10 -> DROP; crsdv=0 -> IDLE; none of these pulse frame_done.
REQ-017 DATA: each dibit SHALL be shifted in so byte = {d3,d2,d1,d0}, d0 being the first dibit of the byte.
REQ-018 byte_valid SHALL be high, with byte_out held, for exactly the cycle following the edge that sampled the 4th dibit of a byte.
REQ-019 A running CRC-32 (reflected, poly 0xEDB88320, init 0xFFFFFFFF, no final inversion) SHALL be updated with every completed byte, FCS bytes included.
REQ-020 DATA with crsdv=0 sampled -> IDLE, and frame_done SHALL pulse on the following cycle with crc_ok/frame_err/byte_count valid in that same cycle.
REQ-021 crc_ok SHALL be 1 iff the CRC register equals 0xDEBB20E3 after the last byte and frame_err=0.
REQ-022 frame_err SHALL be 1 if: dibit count in DATA is not a multiple of 4, or byte_count<64, or eth_rxer was sampled high in DATA, or overflow occurred.
REQ-023 Partial trailing byte SHALL NOT produce byte_valid.
REQ-024 Overflow: completing byte MAX_BYTES+1 SHALL suppress its byte_valid, saturate byte_count at MAX_BYTES, latch the error and enter DROP.
REQ-025 DROP SHALL ignore rxd until crsdv=0 is sampled, then go to IDLE; frame_done (crc_ok=0, frame_err=1) SHALL pulse only if DROP was entered from DATA.
REQ-026 byte_count and CRC SHALL be cleared on the PREAMBLE->DATA transition; byte_count SHALL hold after frame_done until the next SFD.
REQ-027 crc_ok/frame_err SHALL be 0 whenever frame_done is 0.

Reset
REQ-028 rst sampled high SHALL force IDLE and byte_valid=0, byte_out=0, frame_done=0, crc_ok=0, frame_err=0, byte_count=0, CRC=0xFFFFFFFF, counters 0, on the next edge.
REQ-029 rst asserted mid-frame SHALL abort the frame without frame_done; if crsdv is still high with data after release, the block SHALL enter DROP per REQ-015 and wait for crsdv=0.

Verification
REQ-030 31 dibits 01, dibit 11, 60-byte payload 0x00..0x3B, FCS of that payload LSB-byte first, crsdv low -> 64 byte_valid strobes in order, frame_done with crc_ok=1, frame_err=0, byte_count=64.
REQ-031 Same frame with one payload bit flipped -> identical byte stream except that byte, frame_done with crc_ok=0, frame_err=0.
REQ-032 Only 4 preamble dibits then 11 -> DROP, no byte_valid, no frame_done; following good frame received with crc_ok=1.
REQ-033 Good 64-byte frame plus 2 extra dibits before crsdv low -> 64 byte_valid strobes, frame_err=1, crc_ok=0.
REQ-034 1600-byte frame -> exactly 1522 byte_valid strobes, frame_done after crsdv low with byte_count=1522, frame_err=1; rxer pulse in a 64-byte frame -> frame_err=1.
REQ-035 rst pulse at byte 20 of a frame -> all outputs 0 next cycle, no frame_done for that frame, next good frame received with crc_ok=1.
